vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 100 ++++++++++
 tb/tb_vga_timing_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, X/Y raster counters,
// registered syncs, blanking window, line/frame strobes and a frame counter.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 2,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          En,
    output logic          pixel_ce,
    output logic          hs,
    output logic          vs,
    output logic          blank,
    output logic          sync,
    output logic [CW-1:0] DrawX,
    output logic [CW-1:0] DrawY,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // One extra bit so bounds equal to 2**CW still compare exactly.
    localparam int unsigned XW      = CW + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [XW-1:0]    H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0]    V_LAST   = XW'(V_TOTAL - 1);
    localparam logic [XW-1:0]    H_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0]    V_ACT    = XW'(V_ACTIVE);
    localparam logic [XW-1:0]    HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0]    HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0]    VS_START = XW'(V_ACTIVE + V_FP);
    localparam logic [XW-1:0]    VS_END   = XW'(V_ACTIVE + V_FP + V_SYNC);

    if (CLK_DIV == 0 || (64'd1 << CW) < 64'(H_TOTAL) || (64'd1 << CW) < 64'(V_TOTAL)) begin : g_param_check
        $error("vga_timing_gen: CLK_DIV must be >= 1 and 2**CW must cover H_TOTAL and V_TOTAL");
    end

    logic [DIV_W-1:0] div;
    logic [CW-1:0]    x_nxt;
    logic [CW-1:0]    y_nxt;
    logic             x_wrap;
    logic             y_wrap;
    logic             hs_nxt;
    logic             vs_nxt;

    assign pixel_ce    = En && (div == DIV_LAST);
    assign line_start  = pixel_ce && (DrawX == '0);
    assign frame_start = line_start && (DrawY == '0);
    assign blank       = ({1'b0, DrawX} < H_ACT) && ({1'b0, DrawY} < V_ACT);
    assign sync        = 1'b0;

    // Next raster position and the sync levels that belong to it.
    always_comb begin
        x_wrap = ({1'b0, DrawX} == H_LAST);
        y_wrap = ({1'b0, DrawY} == V_LAST);
        x_nxt  = x_wrap ? '0 : DrawX + CW'(1);
        y_nxt  = y_wrap ? '0 : DrawY + CW'(1);
        hs_nxt = ({1'b0, x_nxt} >= HS_START && {1'b0, x_nxt} < HS_END) ? HS_POL : ~HS_POL;
        vs_nxt = ({1'b0, y_nxt} >= VS_START && {1'b0, y_nxt} < VS_END) ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div         <= '0;
            DrawX       <= '0;
            DrawY       <= '0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            frame_count <= '0;
        end else if (En) begin
            div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            if (pixel_ce) begin
                DrawX <= x_nxt;
                hs    <= hs_nxt;
                if (x_wrap) begin
                    DrawY <= y_nxt;
                    vs    <= vs_nxt;
                    if (y_wrap) begin
                        frame_count <= frame_count + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 timing and a tiny override raster,
// both checked every cycle against an arithmetic model of the raster position.
module tb_vga_timing_gen;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        En;

    logic        pce_d, hs_d, vs_d, blank_d, sync_d, ls_d, fs_d;
    logic [9:0]  dx_d, dy_d;
    logic [15:0] fc_d;
    logic        pce_s, hs_s, vs_s, blank_s, sync_s, ls_s, fs_s;
    logic [9:0]  dx_s, dy_s;
    logic [15:0] fc_s;

    int checks   = 0;
    int failures = 0;

    // Enabled clock edges since the last reset; position follows from it by arithmetic.
    longint unsigned c_model;

    always #5 Clk = ~Clk;

    vga_timing_gen dut_def (
        .Clk(Clk), .Reset(Reset), .En(En),
        .pixel_ce(pce_d), .hs(hs_d), .vs(vs_d), .blank(blank_d), .sync(sync_d),
        .DrawX(dx_d), .DrawY(dy_d), .line_start(ls_d), .frame_start(fs_d),
        .frame_count(fc_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b0), .CW(10)
    ) dut_sml (
        .Clk(Clk), .Reset(Reset), .En(En),
        .pixel_ce(pce_s), .hs(hs_s), .vs(vs_s), .blank(blank_s), .sync(sync_s),
        .DrawX(dx_s), .DrawY(dy_s), .line_start(ls_s), .frame_start(fs_s),
        .frame_count(fc_s)
    );

    always @(posedge Clk or posedge Reset) begin
        if (Reset)   c_model <= 0;
        else if (En) c_model <= c_model + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input longint unsigned exp);
        checks++;
        if (act !== 64'(exp)) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input longint unsigned d,
                             input longint unsigned ha, hf, hsw, hb, va, vf, vsw, vb,
                             input bit hpol, vpol,
                             input logic pce, hs_o, vs_o, bl_o, sy_o, ls_o, fs_o,
                             input logic [9:0] x_o, y_o, input logic [15:0] fc_o);
        longint unsigned ht, vt, p, x, y, ln, fc;
        bit pce_e, ls_e, fs_e, hs_e, vs_e, bl_e;
        ht    = ha + hf + hsw + hb;
        vt    = va + vf + vsw + vb;
        p     = c_model / d;
        x     = p % ht;
        ln    = p / ht;
        y     = ln % vt;
        fc    = (ln / vt) % 65536;
        pce_e = En && ((c_model % d) == d - 1);
        ls_e  = pce_e && (x == 0);
        fs_e  = ls_e && (y == 0);
        hs_e  = (x >= ha + hf && x < ha + hf + hsw) ? hpol : !hpol;
        vs_e  = (y >= va + vf && y < va + vf + vsw) ? vpol : !vpol;
        bl_e  = (x < ha) && (y < va);
        check({tag, "_drawx"}, 64'(x_o), x);
        check({tag, "_drawy"}, 64'(y_o), y);
        check({tag, "_frame_count"}, 64'(fc_o), fc);
        check({tag, "_hs"}, 64'(hs_o), 64'(hs_e));
        check({tag, "_vs"}, 64'(vs_o), 64'(vs_e));
        check({tag, "_blank"}, 64'(bl_o), 64'(bl_e));
        check({tag, "_sync"}, 64'(sy_o), 0);
        if (!Reset) begin
            check({tag, "_pixel_ce"}, 64'(pce), 64'(pce_e));
            check({tag, "_line_start"}, 64'(ls_o), 64'(ls_e));
            check({tag, "_frame_start"}, 64'(fs_o), 64'(fs_e));
        end
    endtask

    always @(negedge Clk) begin
        check_dut("def", 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
                  pce_d, hs_d, vs_d, blank_d, sync_d, ls_d, fs_d, dx_d, dy_d, fc_d);
        check_dut("sml", 1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0,
                  pce_s, hs_s, vs_s, blank_s, sync_s, ls_s, fs_s, dx_s, dy_s, fc_s);
    end

    initial begin
        int t;
        int rst_hold;
        int last_fs_s, last_ls_s, last_ls_d;
        int nls_d, nfs_d, hs_low_d, bl_d_cnt, first_hs_x, vs_low_s, hs_hi_s, bl_s_cnt;
        last_fs_s = -1; last_ls_s = -1; last_ls_d = -1;
        nls_d = 0; nfs_d = 0; hs_low_d = 0; bl_d_cnt = 0; first_hs_x = -1;
        vs_low_s = 0; hs_hi_s = 0; bl_s_cnt = 0; rst_hold = 0;

        // Reset held with En high: reset must win.
        Reset = 1'b1;
        En    = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_def_drawx", 64'(dx_d), 0);
        check("rst_def_drawy", 64'(dy_d), 0);
        check("rst_def_hs", 64'(hs_d), 1);
        check("rst_def_vs", 64'(vs_d), 1);
        check("rst_def_fc", 64'(fc_d), 0);
        check("rst_sml_hs", 64'(hs_s), 0);
        @(posedge Clk); #1 Reset = 1'b0;

        // Free run: strobe periods, sync windows, blank area, frame counter.
        for (int n = 0; n < 3300; n++) begin
            @(negedge Clk);
            if (fs_s) begin
                if (last_fs_s >= 0) check("sml_frame_period", 64'(n - last_fs_s), 48);
                last_fs_s = n;
            end
            if (ls_s) begin
                if (last_ls_s >= 0) check("sml_line_period", 64'(n - last_ls_s), 8);
                last_ls_s = n;
            end
            if (ls_d) begin
                if (last_ls_d >= 0) check("def_line_period", 64'(n - last_ls_d), 1600);
                last_ls_d = n;
                nls_d++;
            end
            if (fs_d) nfs_d++;
            if (n >= 1600 && n < 3200) begin
                if (!hs_d) hs_low_d++;
                if (blank_d) bl_d_cnt++;
            end
            if (!hs_d && first_hs_x < 0) first_hs_x = int'(dx_d);
            if (n < 48) begin
                if (!vs_s) vs_low_s++;
                if (blank_s) bl_s_cnt++;
            end
            if (n < 8 && hs_s) hs_hi_s++;
            if (n == 144) check("sml_fc_after_3_frames", 64'(fc_s), 3);
        end
        check("def_line_starts", 64'(nls_d), 3);
        check("def_frame_starts", 64'(nfs_d), 1);
        check("def_hs_low_clks", 64'(hs_low_d), 192);
        check("def_first_hs_x", 64'(first_hs_x), 656);
        check("def_blank_clks", 64'(bl_d_cnt), 1280);
        check("sml_vs_low_clks", 64'(vs_low_s), 8);
        check("sml_hs_high_clks", 64'(hs_hi_s), 2);
        check("sml_blank_clks", 64'(bl_s_cnt), 12);

        // Enable dropped at DrawX=100 for 50 clocks.
        t = 0;
        do begin @(posedge Clk); #1; t++; end while (dx_d != 10'd100 && t < 4000);
        check("def_reach_x100", 64'(dx_d), 100);
        En = 1'b0;
        repeat (50) begin
            @(negedge Clk);
            check("hold_drawx", 64'(dx_d), 100);
            check("hold_pixel_ce", 64'(pce_d), 0);
            check("hold_line_start", 64'(ls_d), 0);
        end
        @(posedge Clk); #1 En = 1'b1;
        t = 0;
        do begin @(posedge Clk); #1; t++; end while (dx_d == 10'd100 && t < 10);
        check("resume_x101", 64'(dx_d), 101);
        t = 0;
        do begin @(posedge Clk); #1; t++; end while (dx_d == 10'd101 && t < 10);
        check("resume_x102", 64'(dx_d), 102);

        // Asynchronous reset mid-line at DrawX=300.
        t = 0;
        do begin @(posedge Clk); #1; t++; end while (dx_d != 10'd300 && t < 4000);
        check("def_reach_x300", 64'(dx_d), 300);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_drawx", 64'(dx_d), 0);
        check("async_rst_drawy", 64'(dy_d), 0);
        check("async_rst_hs", 64'(hs_d), 1);
        check("async_rst_vs", 64'(vs_d), 1);
        check("async_rst_fc_sml", 64'(fc_s), 0);
        @(posedge Clk); #1 Reset = 1'b0;
        t = 0;
        do begin @(negedge Clk); t++; end while (!pce_d && t < 10);
        check("first_pce_seen", 64'(pce_d), 1);
        check("first_pce_frame_start", 64'(fs_d), 1);

        // Random enable pattern with occasional reset pulses.
        for (int i = 0; i < 30000; i++) begin
            @(posedge Clk); #1;
            if (Reset) begin
                if (rst_hold == 0) Reset = 1'b0;
                else rst_hold--;
            end else if ($urandom_range(0, 2999) == 0) begin
                Reset    = 1'b1;
                rst_hold = int'($urandom_range(0, 2));
            end
            En = ($urandom_range(0, 7) != 0);
        end
        @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
